// File: rtl/rx_crc_receiver.sv
// rx_crc_receiver: UART-style serial receiver for a two-byte frame
// (start, 8 data bits LSB first, 8 CRC bits LSB first, stop).
// Optional feature macro: RX_CRC_CHECK_EN. When it is defined, crc_error
// flags a CRC-8 (poly 0x07, init 0x00, MSB-first) mismatch. When it is
// undefined, crc_error is tied to 0 and no CRC logic is built.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   rx_in       serial line, idles high
//   data_out    received data byte
//   crc_out     received CRC byte
//   data_valid  one-cycle pulse when data_out/crc_out/crc_error update
//   crc_error   CRC mismatch flag for the last accepted frame
//   frame_error one-cycle pulse on a bad stop bit
//   rx_busy     high whenever the receiver is not idle
module rx_crc_receiver #(
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic [7:0] crc_out,
  output logic       data_valid,
  output logic       crc_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int unsigned CLK_FREQ   = 50000000;
  localparam int unsigned BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = 13;
  localparam int unsigned BITS_W     = 4;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t              state, state_d;
  logic [1:0]          sync;
  logic                rx_s;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [BITS_W-1:0]   bit_cnt, bit_cnt_d;
  logic [15:0]         shift, shift_d;
  logic                ferr_wait, ferr_wait_d;
  logic [7:0]          data_out_d, crc_out_d;
  logic                data_valid_d, crc_error_d, frame_error_d, rx_busy_d;
  logic                crc_mismatch_c;

  assign rx_s = sync[1];

`ifdef RX_CRC_CHECK_EN
  // CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign crc_mismatch_c = (shift[15:8] != crc8(shift[7:0]));
`else
  assign crc_mismatch_c = 1'b0;
`endif

  // State, synchronizer and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      sync        <= 2'b11;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      ferr_wait   <= 1'b0;
      data_out    <= 8'h00;
      crc_out     <= 8'h00;
      data_valid  <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_d;
      sync        <= {sync[0], rx_in};
      cnt         <= cnt_d;
      bit_cnt     <= bit_cnt_d;
      shift       <= shift_d;
      ferr_wait   <= ferr_wait_d;
      data_out    <= data_out_d;
      crc_out     <= crc_out_d;
      data_valid  <= data_valid_d;
      crc_error   <= crc_error_d;
      frame_error <= frame_error_d;
      rx_busy     <= rx_busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bit_cnt_d     = bit_cnt;
    shift_d       = shift;
    ferr_wait_d   = ferr_wait;
    data_out_d    = data_out;
    crc_out_d     = crc_out;
    crc_error_d   = crc_error;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d       = '0;
        bit_cnt_d   = '0;
        ferr_wait_d = 1'b0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          // A high line at mid-start is a glitch, not a frame
          state_d = rx_s ? IDLE : SHIFT;
        end else begin
          cnt_d = CNT_W'(cnt + 1'b1);
        end
      end

      SHIFT: begin
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift[15:1]};
          bit_cnt_d = BITS_W'(bit_cnt + 1'b1);
          if (bit_cnt == BITS_W'(15)) state_d = STOP;
        end else begin
          cnt_d = CNT_W'(cnt + 1'b1);
        end
      end

      STOP: begin
        if (ferr_wait) begin
          // After a bad stop bit, hold off until the line has recovered
          cnt_d = '0;
          if (rx_s) begin
            state_d     = IDLE;
            ferr_wait_d = 1'b0;
          end
        end else if (cnt == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d      = IDLE;
            data_valid_d = 1'b1;
            data_out_d   = shift[7:0];
            crc_out_d    = shift[15:8];
            crc_error_d  = crc_mismatch_c;
          end else begin
            frame_error_d = 1'b1;
            ferr_wait_d   = 1'b1;
          end
        end else begin
          cnt_d = CNT_W'(cnt + 1'b1);
        end
      end

      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_rx_crc_receiver.sv
// Scoreboard bench for rx_crc_receiver, run at a fast baud so each frame
// is a few hundred clocks (BIT_TICKS = 20, HALF_TICKS = 10).
module tb_rx_crc_receiver;

  localparam int unsigned BAUD = 2500000;
  localparam int unsigned BT   = 50000000 / BAUD;

`ifdef RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out, crc_out;
  logic       data_valid, crc_error, frame_error, rx_busy;

  rx_crc_receiver #(.BAUD_RATE(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .crc_out    (crc_out),
    .data_valid (data_valid),
    .crc_error  (crc_error),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ferr;
    logic [7:0] d;
    logic [7:0] c;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; abort_bit >= 0 pulses reset mid-way through that line bit
  task automatic send_frame(input logic [7:0] d, input logic [7:0] c,
                            input logic stop, input int abort_bit);
    logic [17:0] line;
    line = {stop, c, d, 1'b0};
    for (int i = 0; i < 18; i++) begin
      rx_in = line[i];
      if (i == abort_bit) begin
        tick(BT / 2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(BT - BT / 2 - 1);
      end else begin
        tick(BT);
      end
    end
  endtask

  task automatic expect_valid(input logic [7:0] d, input logic [7:0] c, input logic e);
    exp_t x;
    x.ferr = 1'b0; x.d = d; x.c = c; x.e = e;
    q.push_back(x);
  endtask

  task automatic expect_ferr(input logic [7:0] d, input logic [7:0] c, input logic e);
    exp_t x;
    x.ferr = 1'b1; x.d = d; x.c = c; x.e = e;
    q.push_back(x);
  endtask

  // Monitor: pops an expectation whenever the DUT pulses an output
  logic prev_pulse = 1'b0;
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (data_valid || frame_error) begin
        check("pulse_exclusive", 32'(data_valid & frame_error), 32'd0);
        check("pulse_one_cycle", 32'(prev_pulse), 32'd0);
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          check("pulse_kind_ferr", 32'(frame_error), 32'(x.ferr));
          check("data_out", 32'(data_out), 32'(x.d));
          check("crc_out", 32'(crc_out), 32'(x.c));
          check("crc_error", 32'(crc_error), 32'(x.e));
        end
      end
      prev_pulse = data_valid | frame_error;
    end
  end

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    tick(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_crc_out", 32'(crc_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_crc_error", 32'(crc_error), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    reset = 1'b1;
    tick(5);

    // Good frame, matching CRC
    expect_valid(8'h01, 8'h07, 1'b0);
    send_frame(8'h01, 8'h07, 1'b1, -1);
    tick(10);

    // CRC 0x00 is wrong for 0x80 (correct is 0x89)
    expect_valid(8'h80, 8'h00, CRC_EN);
    send_frame(8'h80, 8'h00, 1'b1, -1);
    tick(10);

    // Short low glitch while idle: false start
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    tick(BT);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    tick(10);

    // Bad stop bit: outputs hold the previous frame's values
    expect_ferr(8'h80, 8'h00, CRC_EN);
    send_frame(8'h55, 8'hAC, 1'b0, -1);
    tick(3 * BT);
    check("ferr_busy_held", 32'(rx_busy), 32'd1);
    rx_in = 1'b1;
    tick(6);
    check("ferr_busy_released", 32'(rx_busy), 32'd0);
    tick(10);

    // Reset during data bit 5 (line bit 6); trailing bits are all high
    send_frame(8'hE0, 8'hFF, 1'b1, 6);
    check("abort_busy_low", 32'(rx_busy), 32'd0);
    tick(10);
    expect_valid(8'h80, 8'h89, 1'b0);
    send_frame(8'h80, 8'h89, 1'b1, -1);
    tick(10);

    // Back-to-back frames, no idle gap
    expect_valid(8'h01, 8'h07, 1'b0);
    expect_valid(8'h80, 8'h89, 1'b0);
    send_frame(8'h01, 8'h07, 1'b1, -1);
    send_frame(8'h80, 8'h89, 1'b1, -1);
    tick(4 * BT);

    check("all_expected_seen", 32'(q.size()), 32'd0);
    check("final_busy_low", 32'(rx_busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
